// File: rtl/upht_ctrl.sv
// Micro-PHT direction predictor control: gshare-style index, write forwarding,
// in-flight prediction queue, counter update on resolve and flush on mispredict.
module upht_ctrl #(
   parameter int SAT_TABLE_SIZE = 64,
   parameter int PC_W           = 32,
   parameter int Q_DEPTH        = 4,
   localparam int IDX_W         = $clog2(SAT_TABLE_SIZE),
   localparam int GHR_W         = IDX_W
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_pred_req,
   input  logic [PC_W-1:0]  i_pred_pc,
   input  logic [1:0]       i_upht_cnt,
   input  logic             i_res_vld,
   input  logic             i_res_taken,
   output logic             o_upht_rd_vld,
   output logic [IDX_W-1:0] o_upht_rd_addr,
   output logic             o_pred_vld,
   output logic             o_pred_taken,
   output logic             o_full,
   output logic             o_mispredict,
   output logic             o_upht_wr_vld,
   output logic [IDX_W-1:0] o_upht_wr_addr,
   output logic [1:0]       o_commit_cnt
);

   localparam int QW = $clog2(Q_DEPTH);
   localparam logic [QW:0] FULL_OCC = (QW+1)'(Q_DEPTH);

   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [QW:0]      wr_ptr_q, wr_ptr_d;
   logic [QW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_vld_q, wr_vld_d;
   logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
   logic [1:0]       commit_q, commit_d;
   logic             mispred_q, mispred_d;

   logic [IDX_W-1:0] q_idx_q [Q_DEPTH];
   logic [1:0]       q_cnt_q [Q_DEPTH];
   logic [GHR_W-1:0] q_ghr_q [Q_DEPTH];
   logic             q_dir_q [Q_DEPTH];

   logic [IDX_W-1:0] rd_addr;
   logic [1:0]       eff_cnt;
   logic [QW:0]      occ;
   logic             full, empty;
   logic [QW-1:0]    head, tail;
   logic [IDX_W-1:0] head_idx;
   logic [1:0]       head_cnt;
   logic [GHR_W-1:0] head_ghr;
   logic             head_dir;
   logic             pop, flush, push;
   logic [1:0]       sat_cnt;
   logic             unused_bits;

   assign rd_addr  = i_pred_pc[IDX_W+1:2] ^ ghr_q;
   assign eff_cnt  = (wr_vld_q && (wr_addr_q == rd_addr)) ? commit_q : i_upht_cnt;
   assign occ      = wr_ptr_q - rd_ptr_q;
   assign full     = (occ == FULL_OCC);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign head     = rd_ptr_q[QW-1:0];
   assign tail     = wr_ptr_q[QW-1:0];
   assign head_idx = q_idx_q[head];
   assign head_cnt = q_cnt_q[head];
   assign head_ghr = q_ghr_q[head];
   assign head_dir = q_dir_q[head];
   assign pop      = i_res_vld & ~empty;
   assign flush    = pop & (i_res_taken != head_dir);
   assign push     = i_pred_req & ~full & ~flush;

   assign unused_bits = ^{i_pred_pc[PC_W-1:IDX_W+2], i_pred_pc[1:0], head_ghr[GHR_W-1]};

   assign o_upht_rd_vld  = i_pred_req;
   assign o_upht_rd_addr = rd_addr;
   assign o_pred_vld     = push;
   assign o_pred_taken   = eff_cnt[1];
   assign o_full         = full;
   assign o_mispredict   = mispred_q;
   assign o_upht_wr_vld  = wr_vld_q;
   assign o_upht_wr_addr = wr_addr_q;
   assign o_commit_cnt   = commit_q;

   // Saturating 2-bit counter update toward the resolved outcome.
   always_comb begin
      sat_cnt = head_cnt;
      if (i_res_taken) begin
         if (head_cnt != 2'd3) sat_cnt = head_cnt + 2'd1;
      end else begin
         if (head_cnt != 2'd0) sat_cnt = head_cnt - 2'd1;
      end
   end

   // Next-state for history, queue pointers and the registered write port.
   always_comb begin
      ghr_d     = ghr_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_vld_d  = pop;
      wr_addr_d = wr_addr_q;
      commit_d  = commit_q;
      mispred_d = flush;
      if (pop) begin
         wr_addr_d = head_idx;
         commit_d  = sat_cnt;
      end
      if (flush) begin
         ghr_d    = {head_ghr[GHR_W-2:0], i_res_taken};
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            ghr_d    = {ghr_q[GHR_W-2:0], eff_cnt[1]};
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Control state with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ghr_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         commit_q  <= '0;
         mispred_q <= 1'b0;
      end else begin
         ghr_q     <= ghr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_vld_q  <= wr_vld_d;
         wr_addr_q <= wr_addr_d;
         commit_q  <= commit_d;
         mispred_q <= mispred_d;
      end
   end

   // Queue payload storage; validity is tracked solely by the pointers.
   always_ff @(posedge i_clk) begin
      if (push) begin
         q_idx_q[tail] <= rd_addr;
         q_cnt_q[tail] <= eff_cnt;
         q_ghr_q[tail] <= ghr_q;
         q_dir_q[tail] <= eff_cnt[1];
      end
   end

endmodule

// File: tb/tb_upht_ctrl.sv
// Scoreboard bench for upht_ctrl: expected predictions and writes are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_upht_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_pred_req;
   logic [31:0] i_pred_pc;
   logic [1:0]  i_upht_cnt;
   logic        i_res_vld;
   logic        i_res_taken;
   logic        o_upht_rd_vld;
   logic [5:0]  o_upht_rd_addr;
   logic        o_pred_vld;
   logic        o_pred_taken;
   logic        o_full;
   logic        o_mispredict;
   logic        o_upht_wr_vld;
   logic [5:0]  o_upht_wr_addr;
   logic [1:0]  o_commit_cnt;

   upht_ctrl dut (
      .i_clk          (i_clk),
      .i_rstn         (i_rstn),
      .i_pred_req     (i_pred_req),
      .i_pred_pc      (i_pred_pc),
      .i_upht_cnt     (i_upht_cnt),
      .i_res_vld      (i_res_vld),
      .i_res_taken    (i_res_taken),
      .o_upht_rd_vld  (o_upht_rd_vld),
      .o_upht_rd_addr (o_upht_rd_addr),
      .o_pred_vld     (o_pred_vld),
      .o_pred_taken   (o_pred_taken),
      .o_full         (o_full),
      .o_mispredict   (o_mispredict),
      .o_upht_wr_vld  (o_upht_wr_vld),
      .o_upht_wr_addr (o_upht_wr_addr),
      .o_commit_cnt   (o_commit_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [5:0] addr;
      logic       tk;
   } pe_t;

   typedef struct {
      logic [5:0] addr;
      logic [1:0] cnt;
      logic       mp;
   } we_t;

   pe_t exp_pred[$];
   we_t exp_wr[$];
   int  n_tot  = 0;
   int  n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic ep(input logic [5:0] a, input logic t);
      pe_t e;
      e.addr = a;
      e.tk   = t;
      exp_pred.push_back(e);
   endtask

   task automatic ew(input logic [5:0] a, input logic [1:0] c, input logic m);
      we_t e;
      e.addr = a;
      e.cnt  = c;
      e.mp   = m;
      exp_wr.push_back(e);
   endtask

   task automatic cyc(input logic req, input logic [31:0] pc, input logic [1:0] cnt,
                      input logic rv, input logic rt);
      @(posedge i_clk);
      #1;
      i_pred_req  = req;
      i_pred_pc   = pc;
      i_upht_cnt  = cnt;
      i_res_vld   = rv;
      i_res_taken = rt;
      @(negedge i_clk);
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
   endtask

   // Monitor: every DUT-presented prediction or write must match the queue head.
   always @(negedge i_clk) begin
      if (i_rstn) begin
         if (o_pred_vld) begin
            if (exp_pred.size() == 0) begin
               n_tot++;
               $display("FAIL pred_unexpected: got addr %0h want none", o_upht_rd_addr);
            end else begin
               pe_t e;
               e = exp_pred.pop_front();
               chk("pred_addr", 32'(o_upht_rd_addr), 32'(e.addr));
               chk("pred_taken", 32'(o_pred_taken), 32'(e.tk));
            end
         end
         if (o_upht_wr_vld) begin
            if (exp_wr.size() == 0) begin
               n_tot++;
               $display("FAIL wr_unexpected: got addr %0h want none", o_upht_wr_addr);
            end else begin
               we_t w;
               w = exp_wr.pop_front();
               chk("wr_addr", 32'(o_upht_wr_addr), 32'(w.addr));
               chk("commit_cnt", 32'(o_commit_cnt), 32'(w.cnt));
               chk("mispredict", 32'(o_mispredict), 32'(w.mp));
            end
         end else if (o_mispredict) begin
            n_tot++;
            $display("FAIL mispredict_stray: got 1 want 0");
         end
      end
   end

   initial begin
      i_rstn      = 1'b0;
      i_pred_req  = 1'b1;
      i_pred_pc   = 32'h104;
      i_upht_cnt  = 2'd2;
      i_res_vld   = 1'b0;
      i_res_taken = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("rst_full", 32'(o_full), 0);
      chk("rst_wr_vld", 32'(o_upht_wr_vld), 0);
      chk("rst_wr_addr", 32'(o_upht_wr_addr), 0);
      chk("rst_commit", 32'(o_commit_cnt), 0);
      chk("rst_mispredict", 32'(o_mispredict), 0);
      chk("rst_rd_addr", 32'(o_upht_rd_addr), 32'h01);
      @(posedge i_clk);
      #1;
      i_rstn     = 1'b1;
      i_pred_req = 1'b0;

      // Basic prediction and history shift
      ep(6'h01, 1'b1);
      cyc(1'b1, 32'h104, 2'd2, 1'b0, 1'b0);
      chk("rd_vld", 32'(o_upht_rd_vld), 1);
      ep(6'h01, 1'b1);
      cyc(1'b1, 32'h000, 2'd3, 1'b0, 1'b0);
      ew(6'h01, 2'd3, 1'b0);
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      ew(6'h01, 2'd3, 1'b0);
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();

      // Correct not-taken, then mispredict with a younger entry queued
      ep(6'h01, 1'b0);
      cyc(1'b1, 32'h008, 2'd0, 1'b0, 1'b0);
      ew(6'h01, 2'd0, 1'b0);
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      idle();
      ep(6'h05, 1'b0);
      cyc(1'b1, 32'h00C, 2'd1, 1'b0, 1'b0);
      ep(6'h08, 1'b1);
      cyc(1'b1, 32'h010, 2'd2, 1'b0, 1'b0);
      ew(6'h05, 2'd2, 1'b1);
      cyc(1'b1, 32'h000, 2'd0, 1'b1, 1'b1);
      chk("flush_blocks_push", 32'(o_pred_vld), 0);
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      ep(6'h0D, 1'b0);
      cyc(1'b1, 32'h000, 2'd1, 1'b0, 1'b0);
      chk("empty_res_no_wr", 32'(o_upht_wr_vld), 0);
      chk("mispredict_one_cycle", 32'(o_mispredict), 0);
      ew(6'h0D, 2'd0, 1'b0);
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      idle();

      // Fill the queue
      ep(6'h1A, 1'b1);
      cyc(1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      ep(6'h35, 1'b1);
      cyc(1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      ep(6'h2B, 1'b1);
      cyc(1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      ep(6'h17, 1'b1);
      cyc(1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      cyc(1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      chk("full_set", 32'(o_full), 1);
      chk("full_no_pred", 32'(o_pred_vld), 0);
      chk("full_ghr_hold", 32'(o_upht_rd_addr), 32'h2F);
      ew(6'h1A, 2'd3, 1'b0);
      cyc(1'b1, 32'h0, 2'd2, 1'b1, 1'b1);
      chk("full_pop_no_push", 32'(o_pred_vld), 0);
      ep(6'h2F, 1'b1);
      ew(6'h35, 2'd3, 1'b0);
      cyc(1'b1, 32'h0, 2'd2, 1'b1, 1'b1);
      chk("full_clear", 32'(o_full), 0);
      idle();
      chk("push_pop_occ", 32'(o_full), 0);

      // Reset with three entries in flight
      @(posedge i_clk);
      #1;
      i_rstn = 1'b0;
      #1;
      chk("midrst_full", 32'(o_full), 0);
      chk("midrst_wr_vld", 32'(o_upht_wr_vld), 0);
      @(negedge i_clk);
      chk("midrst_commit", 32'(o_commit_cnt), 0);
      @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      idle();
      chk("postrst_no_wr", 32'(o_upht_wr_vld), 0);

      // Write forwarding into a same-cycle read of the same index
      ep(6'h05, 1'b1);
      cyc(1'b1, 32'h014, 2'd3, 1'b0, 1'b0);
      ew(6'h05, 2'd3, 1'b0);
      cyc(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
      ep(6'h05, 1'b1);
      cyc(1'b1, 32'h010, 2'd0, 1'b0, 1'b0);
      chk("fwd_taken", 32'(o_pred_taken), 1);
      idle();
      idle();

      chk("pred_queue_drained", 32'(exp_pred.size()), 0);
      chk("wr_queue_drained", 32'(exp_wr.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/upht_ctrl.md
UPHT_CTRL -- requirements
Module: upht_ctrl

Interface
REQ-001 SHALL have parameter SAT_TABLE_SIZE, default 64, micro-PHT entry count (power of two).
REQ-002 SHALL have parameter PC_W, default 32, fetch PC width.
REQ-003 SHALL have parameter Q_DEPTH, default 4, in-flight prediction queue depth (power of two).
REQ-004 SHALL define IDX_W = log2(SAT_TABLE_SIZE) and GHR_W = IDX_W.
REQ-005 i_clk  input  1  clock, all state on rising edge.
REQ-006 i_rstn  input  1  reset, asynchronous, active-low.
REQ-007 i_pred_req  input  1  fetch requests a direction prediction this cycle.
REQ-008 i_pred_pc  input  PC_W  PC of branch being predicted.
REQ-009 i_upht_cnt  input  2  counter returned by micro-PHT for o_upht_rd_addr, same cycle.
REQ-010 i_res_vld  input  1  oldest in-flight branch resolved this cycle.
REQ-011 i_res_taken  input  1  actual outcome of resolved branch.
REQ-012 o_upht_rd_vld  output  1  micro-PHT read enable.
REQ-013 o_upht_rd_addr  output  IDX_W  micro-PHT read index.
REQ-014 o_pred_vld  output  1  prediction accepted this cycle.
REQ-015 o_pred_taken  output  1  predicted direction.
REQ-016 o_full  output  1  queue full; fetch must hold.
REQ-017 o_mispredict  output  1  registered pulse, resolved outcome differed from prediction.
REQ-018 o_upht_wr_vld  output  1  micro-PHT write enable.
REQ-019 o_upht_wr_addr  output  IDX_W  micro-PHT write index.
REQ-020 o_commit_cnt  output  2  new counter value to write.

Function
REQ-021 Read index SHALL be i_pred_pc[IDX_W+1:2] XOR GHR; o_upht_rd_vld = i_pred_req; both combinational.
REQ-022 Effective counter SHALL be o_commit_cnt when o_upht_wr_vld is high and o_upht_wr_addr equals o_upht_rd_addr (write forwarding), else i_upht_cnt.
REQ-023 o_pred_taken SHALL be bit 1 of effective counter; o_pred_vld = i_pred_req AND NOT o_full AND NOT flush-this-cycle; combinational, zero latency.
REQ-024 On accepted prediction, queue SHALL push {index, effective counter, pre-update GHR, predicted direction} and GHR SHALL shift left inserting o_pred_taken at bit 0.
REQ-025 Flush-this-cycle SHALL be i_res_vld AND queue non-empty AND i_res_taken differs from head predicted direction.
REQ-026 On i_res_vld with non-empty queue, head SHALL pop; next cycle o_upht_wr_vld=1, o_upht_wr_addr=head index, o_commit_cnt = head counter +1 saturating at 3 if taken, -1 saturating at 0 if not taken.
REQ-027 On flush, GHR SHALL become {head GHR[GHR_W-2:0], i_res_taken}, all queue entries SHALL be discarded, o_mispredict SHALL pulse one cycle later.
REQ-028 Correct resolution SHALL leave GHR and younger entries unchanged.
REQ-029 i_res_vld with empty queue SHALL be ignored: no write, no GHR change.
REQ-030 o_full SHALL assert when occupancy equals Q_DEPTH; push blocked even if pop occurs same cycle.
REQ-031 Simultaneous push and correct-pop on non-full queue SHALL keep occupancy constant.
REQ-032 Queue pointers SHALL wrap modulo Q_DEPTH with an extra bit distinguishing full/empty.
REQ-033 o_upht_wr_vld SHALL be low in any cycle not following a valid resolution.

Reset
REQ-034 On i_rstn low, GHR=0, queue empty, o_upht_wr_vld=0, o_upht_wr_addr=0, o_commit_cnt=0, o_mispredict=0, o_full=0, effective immediately.
REQ-035 Reset mid-operation SHALL discard all in-flight entries without issuing writes.
REQ-036 Combinational outputs SHALL follow REQ-021..023 with GHR=0 during and after reset.

Verification
REQ-037 Reset, i_pred_req=1, pc=0x100, i_upht_cnt=2 -> rd_addr=0x00 (0x40 bit field XOR 0; pc[7:2]=0x00... use pc=0x104 -> rd_addr=0x01), pred_taken=1, GHR becomes 0x01.
REQ-038 Push one prediction cnt=3, resolve taken -> next cycle wr_vld=1, commit_cnt=3 (saturation), no mispredict.
REQ-039 Push cnt=0 predicted not-taken, resolve not-taken -> commit_cnt=0; then cnt=1 resolved taken -> commit_cnt=2, mispredict pulse, queue empty, GHR = head GHR shifted with 1.
REQ-040 Push 4 predictions without resolve -> o_full=1, 5th request gives o_pred_vld=0, GHR unchanged; resolve + request same cycle -> no push.
REQ-041 Write to index 5 in cycle N, read index 5 in cycle N with i_upht_cnt=0 and o_commit_cnt=3 -> pred_taken=1 (forwarding).
REQ-042 Assert i_rstn low with 3 entries queued -> o_full=0, no write issued, following resolve ignored.
